// File: rtl/ama_riscv_pkg.sv
// Shared MMIO/UART definitions: state enums and frame geometry.
package ama_riscv_pkg;

  localparam int UART_FRAME_BITS = 10;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } uart_tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_rx_state_t;

endpackage

// File: rtl/ama_riscv_mmio_rx_fifo.sv
// UART receive buffer.
// MMIO_UART_RX_FIFO_EN defined: DEPTH-entry circular FIFO (DEPTH a power of 2, >= 2).
// Undefined: single holding register with a valid bit.
// A push while full is dropped unless a pop happens in the same cycle.
module ama_riscv_mmio_rx_fifo
  import ama_riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [UART_DATA_BITS-1:0] push_data,
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic [UART_DATA_BITS-1:0] head
);

  logic do_push;
  logic do_pop;

`ifdef MMIO_UART_RX_FIFO_EN
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one extra MSB so equal indices can mean either empty or full.
  logic [AW:0]               wr_ptr;
  logic [AW:0]               rd_ptr;
  logic [UART_DATA_BITS-1:0] mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Circular buffer storage and pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
`else
  logic                      hold_valid;
  logic [UART_DATA_BITS-1:0] hold_data;

  assign empty   = !hold_valid;
  assign full    = hold_valid;
  assign head    = hold_data;
  assign do_pop  = pop && hold_valid;
  assign do_push = push && (!hold_valid || do_pop);

  // Single-entry holding register; a new byte replaces one popped in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (do_push) begin
      hold_valid <= 1'b1;
      hold_data  <= push_data;
    end else if (do_pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/ama_riscv_mmio_uart.sv
// MMIO peripheral beside the core: cycle / retired-instruction counters,
// 8N1 UART transmitter and 8N1 UART receiver with receive buffer.
// Build option MMIO_UART_RX_FIFO_EN selects a RX_FIFO_DEPTH-entry receive FIFO
// instead of the default single holding register.
module ama_riscv_mmio_uart
  import ama_riscv_pkg::*;
#(
  parameter int CLOCK_FREQ    = 100_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        store_to_uart,
  input  logic        load_from_uart,
  input  logic        inst_wb_nop_or_clear,
  input  logic        mmio_reset_cnt,
  input  logic [7:0]  mmio_uart_data_in,
  input  logic        serial_in,
  output logic [31:0] mmio_instr_cnt,
  output logic [31:0] mmio_cycle_cnt,
  output logic [7:0]  mmio_uart_data_out,
  output logic        mmio_data_out_valid,
  output logic        mmio_data_in_ready,
  output logic        serial_out
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = 1;
  localparam logic [3:0] TX_LAST_BIT = 4'(UART_FRAME_BITS - 1);
  localparam logic [2:0] RX_LAST_BIT = 3'(UART_DATA_BITS - 1);

  // ---------------------------------------------------------------- counters
  // Free-running cycle counter and retired-instruction counter; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmio_cycle_cnt <= '0;
      mmio_instr_cnt <= '0;
    end else if (mmio_reset_cnt) begin
      mmio_cycle_cnt <= '0;
      mmio_instr_cnt <= '0;
    end else begin
      mmio_cycle_cnt <= mmio_cycle_cnt + 32'd1;
      if (!inst_wb_nop_or_clear) mmio_instr_cnt <= mmio_instr_cnt + 32'd1;
    end
  end

  // ---------------------------------------------------------------- TX
  uart_tx_state_t tx_state;
  logic [UART_FRAME_BITS-2:0] tx_shift;    // data bits then stop bit still to send
  logic [3:0]                 tx_bit_cnt;  // index of the bit currently on the line
  logic [CNT_W-1:0]           tx_clk_cnt;

  // Serializer: start bit goes out the cycle after accept, each bit held CLKS_PER_BIT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state           <= TX_IDLE;
      tx_shift           <= '0;
      tx_bit_cnt         <= '0;
      tx_clk_cnt         <= '0;
      serial_out         <= 1'b1;
      mmio_data_in_ready <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (store_to_uart && mmio_data_in_ready) begin
            tx_shift           <= {1'b1, mmio_uart_data_in};
            serial_out         <= 1'b0;
            tx_bit_cnt         <= '0;
            tx_clk_cnt         <= '0;
            mmio_data_in_ready <= 1'b0;
            tx_state           <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (tx_clk_cnt == BIT_LAST) begin
            tx_clk_cnt <= '0;
            if (tx_bit_cnt == TX_LAST_BIT) begin
              serial_out         <= 1'b1;
              mmio_data_in_ready <= 1'b1;
              tx_state           <= TX_IDLE;
            end else begin
              serial_out <= tx_shift[0];
              tx_shift   <= {1'b0, tx_shift[UART_FRAME_BITS-2:1]};
              tx_bit_cnt <= tx_bit_cnt + 4'd1;
            end
          end else begin
            tx_clk_cnt <= tx_clk_cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  uart_rx_state_t rx_state;
  logic                      rx_sync1;
  logic                      rx_sync2;
  logic                      rx_prev;
  logic [UART_DATA_BITS-1:0] rx_shift;
  logic [2:0]                rx_bit_cnt;
  logic [CNT_W-1:0]          rx_clk_cnt;
  logic                      rx_stop_ok;
  logic                      rx_full;
  logic                      rx_empty;
  logic                      fifo_push;
  logic                      fifo_pop;

  // Two-flop synchronizer plus one delay flop for falling-edge detection; idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= serial_in;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
    end
  end

  // Deserializer: half-bit wait validates the start bit, then samples at bit centres.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      rx_shift   <= '0;
      rx_bit_cnt <= '0;
      rx_clk_cnt <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync2) begin
            rx_clk_cnt <= '0;
            rx_state   <= RX_START;
          end
        end
        RX_START: begin
          if (rx_clk_cnt == HALF_LAST) begin
            rx_clk_cnt <= '0;
            rx_bit_cnt <= '0;
            rx_state   <= rx_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_clk_cnt <= rx_clk_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_clk_cnt == BIT_LAST) begin
            rx_clk_cnt <= '0;
            rx_shift   <= {rx_sync2, rx_shift[UART_DATA_BITS-1:1]};
            if (rx_bit_cnt == RX_LAST_BIT) rx_state <= RX_STOP;
            else rx_bit_cnt <= rx_bit_cnt + 3'd1;
          end else begin
            rx_clk_cnt <= rx_clk_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_clk_cnt == BIT_LAST) begin
            rx_clk_cnt <= '0;
            rx_state   <= RX_IDLE;
          end else begin
            rx_clk_cnt <= rx_clk_cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  // A good stop bit hands the byte to the buffer on the same edge it is sampled.
  assign rx_stop_ok = (rx_state == RX_STOP) && (rx_clk_cnt == BIT_LAST) && rx_sync2;
  assign fifo_pop   = load_from_uart && !rx_empty;
  assign fifo_push  = rx_stop_ok && (!rx_full || fifo_pop);

  ama_riscv_mmio_rx_fifo #(
    .DEPTH(RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data(rx_shift),
    .pop      (fifo_pop),
    .full     (rx_full),
    .empty    (rx_empty),
    .head     (mmio_uart_data_out)
  );

  assign mmio_data_out_valid = !rx_empty;

endmodule
